// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the core memory stage
// (requester 0) and an auxiliary debug/DMA requester (requester 1).
// One requester is granted per cycle. The core is stalled when it loses the
// port. The auxiliary side can lock the port across beats, for example for
// read-modify-write. Auxiliary read data is returned registered, one cycle
// after the grant.
//
// Optional feature macro: DMEM_ARB_STARVE_GUARD_EN
//   When defined, the auxiliary requester is force-granted after STARVE_LIMIT
//   consecutive denied cycles. When undefined, the core has fixed priority.
//
// Parameters
//   STARVE_LIMIT  denied aux cycles before a forced grant (1..15)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   coreReq/Wen/Addr/Wdata/Size  core memory-stage request
//   coreRdata                    combinational load data (dmemRdata)
//   coreStall                    core lost the port this cycle
//   auxReq/Wen/Addr/Wdata/Size   auxiliary request
//   auxLock                      keep the port for the next aux beat
//   auxGnt                       aux beat accepted this cycle
//   auxRvalid, auxRdata          registered aux read return (1-cycle pulse)
//   dmemAddr/Wdata/Size/Wen      memory port
//   dmemRdata                    combinational memory read data
//   dbg_state                    current arbiter state (debug)
//
// Handshakes
//   aux:  valid/ready. auxReq is valid and auxGnt is ready. A beat transfers
//         on a cycle with auxReq && auxGnt. The request fields must stay
//         stable from the rise of auxReq until that cycle.
//   core: no ready signal. While coreStall=1 the memory stage must repeat the
//         same request next cycle. Nothing on the core side is registered.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coreReq,
  input  logic        coreWen,
  input  logic [31:0] coreAddr,
  input  logic [31:0] coreWdata,
  input  logic [2:0]  coreSize,
  output logic [31:0] coreRdata,
  output logic        coreStall,
  input  logic        auxReq,
  input  logic        auxWen,
  input  logic [31:0] auxAddr,
  input  logic [31:0] auxWdata,
  input  logic [2:0]  auxSize,
  input  logic        auxLock,
  output logic        auxGnt,
  output logic        auxRvalid,
  output logic [31:0] auxRdata,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [2:0]  dmemSize,
  output logic        dmemWen,
  input  logic [31:0] dmemRdata,
  output logic        dbg_state
);

  typedef enum logic {
    OWN_CORE   = 1'b0,
    AUX_LOCKED = 1'b1
  } state_t;

  state_t state, state_next;
  logic   core_gnt;
  logic   aux_gnt;
  logic   starve_force;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  // Counts consecutive denied aux cycles while the core owns the port. It
  // saturates at the limit and holds there until aux is finally granted.
  logic [3:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (aux_gnt) begin
      starve_cnt <= 4'd0;
    end else if (state == OWN_CORE && auxReq && starve_cnt != 4'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign starve_force = (starve_cnt == 4'(STARVE_LIMIT));
`else
  assign starve_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OWN_CORE;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision and next state. Reset overrides everything so that a beat
  // that coincides with rst is neither written nor captured.
  always_comb begin
    core_gnt   = 1'b0;
    aux_gnt    = 1'b0;
    state_next = state;
    if (!rst) begin
      case (state)
        OWN_CORE: begin
          if (auxReq && starve_force) begin
            aux_gnt = 1'b1;
          end else if (coreReq) begin
            core_gnt = 1'b1;
          end else if (auxReq) begin
            aux_gnt = 1'b1;
          end
        end
        AUX_LOCKED: begin
          aux_gnt = auxReq;
        end
        default: begin
          state_next = OWN_CORE;
        end
      endcase
      if (aux_gnt) begin
        state_next = auxLock ? AUX_LOCKED : OWN_CORE;
      end
    end
  end

  // The core fields are the idle default on the port, with the write enable
  // held low.
  always_comb begin
    dmemAddr  = coreAddr;
    dmemWdata = coreWdata;
    dmemSize  = coreSize;
    dmemWen   = 1'b0;
    if (aux_gnt) begin
      dmemAddr  = auxAddr;
      dmemWdata = auxWdata;
      dmemSize  = auxSize;
      dmemWen   = auxWen;
    end else if (core_gnt) begin
      dmemWen   = coreWen;
    end
  end

  // The aux side holds the port either by winning this cycle or by owning the
  // lock, including idle locked cycles.
  assign coreStall = !rst && coreReq && (aux_gnt || state == AUX_LOCKED);
  assign auxGnt    = aux_gnt;
  assign coreRdata = dmemRdata;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      auxRvalid <= 1'b0;
      auxRdata  <= 32'd0;
    end else begin
      auxRvalid <= aux_gnt && !auxWen;
      if (aux_gnt && !auxWen) begin
        auxRdata <= dmemRdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A small word-addressed memory model sits on
// the dmem port: reads are combinational and writes commit at the clock edge.
// Inputs change 1 ns after a rising edge. Outputs are checked on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        coreReq, coreWen;
  logic [31:0] coreAddr, coreWdata;
  logic [2:0]  coreSize;
  logic [31:0] coreRdata;
  logic        coreStall;
  logic        auxReq, auxWen, auxLock;
  logic [31:0] auxAddr, auxWdata;
  logic [2:0]  auxSize;
  logic        auxGnt, auxRvalid;
  logic [31:0] auxRdata;
  logic [31:0] dmemAddr, dmemWdata;
  logic [2:0]  dmemSize;
  logic        dmemWen;
  logic [31:0] dmemRdata;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .coreReq(coreReq), .coreWen(coreWen), .coreAddr(coreAddr),
    .coreWdata(coreWdata), .coreSize(coreSize),
    .coreRdata(coreRdata), .coreStall(coreStall),
    .auxReq(auxReq), .auxWen(auxWen), .auxAddr(auxAddr),
    .auxWdata(auxWdata), .auxSize(auxSize), .auxLock(auxLock),
    .auxGnt(auxGnt), .auxRvalid(auxRvalid), .auxRdata(auxRdata),
    .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemSize(dmemSize),
    .dmemWen(dmemWen), .dmemRdata(dmemRdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  always_comb dmemRdata = mem[dmemAddr[9:2]];
  always @(posedge clk) begin
    if (dmemWen) mem[dmemAddr[9:2]] <= dmemWdata;
  end

  // ---------------- driver tasks ----------------
  task automatic core_drive(input logic req, input logic wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
    coreReq   = req;
    coreWen   = wen;
    coreAddr  = addr;
    coreWdata = wdata;
    coreSize  = 3'b010;
  endtask

  task automatic aux_drive(input logic req, input logic wen, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wdata);
    auxReq   = req;
    auxWen   = wen;
    auxLock  = lock;
    auxAddr  = addr;
    auxWdata = wdata;
    auxSize  = 3'b010;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard entry for an aux read return.
  task automatic chk_rdata(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed %h expected <empty queue>", tag, auxRdata);
    end else begin
      e = exp_q.pop_front();
      chk(tag, auxRdata, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h80] = 32'h1234_5678;   // 0x200
    mem[8'h10] = 32'hCAFE_F00D;   // 0x40
    mem[8'h11] = 32'h0BAD_F00D;   // 0x44

    rst = 1'b1;
    core_drive(1'b1, 1'b1, 32'h100, 32'h5555_5555);
    aux_drive(1'b1, 1'b1, 1'b1, 32'h104, 32'h6666_6666);
    sample();
    chk("rst_auxGnt",    {31'd0, auxGnt},    32'd0);
    chk("rst_coreStall", {31'd0, coreStall}, 32'd0);
    chk("rst_dmemWen",   {31'd0, dmemWen},   32'd0);
    advance();
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    aux_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    advance();
    rst = 1'b0;
    sample();
    chk("reset_auxRvalid", {31'd0, auxRvalid}, 32'd0);
    chk("reset_auxRdata",  auxRdata,           32'd0);
    chk("reset_state",     {31'd0, dbg_state}, 32'd0);
    chk("reset_mem_clean", mem[8'h40],         32'd0);

    // Core store with aux idle.
    advance();
    core_drive(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    sample();
    chk("cst_dmemWen",    {31'd0, dmemWen},   32'd1);
    chk("cst_dmemAddr",   dmemAddr,           32'h100);
    chk("cst_dmemWdata",  dmemWdata,          32'hDEAD_BEEF);
    chk("cst_coreStall",  {31'd0, coreStall}, 32'd0);
    chk("cst_auxGnt",     {31'd0, auxGnt},    32'd0);
    advance();
    core_drive(1'b1, 1'b0, 32'h100, 32'h0);
    sample();
    chk("cld_coreRdata", coreRdata,         32'hDEAD_BEEF);
    chk("cld_dmemWen",   {31'd0, dmemWen},  32'd0);

    // Core idle, aux read of 0x200.
    advance();
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    aux_drive(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    exp_q.push_back(32'h1234_5678);
    sample();
    chk("ard_auxGnt",   {31'd0, auxGnt},  32'd1);
    chk("ard_dmemAddr", dmemAddr,         32'h200);
    chk("ard_dmemWen",  {31'd0, dmemWen}, 32'd0);
    advance();
    aux_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("ard_rvalid1", {31'd0, auxRvalid}, 32'd1);
    chk_rdata("ard_rdata");
    advance();
    sample();
    chk("ard_rvalid0", {31'd0, auxRvalid}, 32'd0);

    // Aux write, core idle: no read return.
    advance();
    aux_drive(1'b1, 1'b1, 1'b0, 32'h204, 32'h0000_A5A5);
    sample();
    chk("awr_auxGnt",  {31'd0, auxGnt},  32'd1);
    chk("awr_dmemWen", {31'd0, dmemWen}, 32'd1);
    advance();
    aux_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("awr_no_rvalid", {31'd0, auxRvalid}, 32'd0);
    chk("awr_mem",       mem[8'h81],         32'h0000_A5A5);

    // Locked read-modify-write.
    advance();
    aux_drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
    exp_q.push_back(32'h0BAD_F00D);
    sample();
    chk("lk0_auxGnt", {31'd0, auxGnt}, 32'd1);
    advance();
    core_drive(1'b1, 1'b1, 32'h300, 32'hFFFF_FFFF);
    aux_drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    sample();
    chk("lkidle_state",     {31'd0, dbg_state}, 32'd1);
    chk("lkidle_coreStall", {31'd0, coreStall}, 32'd1);
    chk("lkidle_dmemWen",   {31'd0, dmemWen},   32'd0);
    chk("lkidle_auxGnt",    {31'd0, auxGnt},    32'd0);
    chk_rdata("lk0_rdata");
    advance();
    aux_drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    exp_q.push_back(32'hCAFE_F00D);
    sample();
    chk("lk1_auxGnt",    {31'd0, auxGnt},    32'd1);
    chk("lk1_coreStall", {31'd0, coreStall}, 32'd1);
    chk("lk1_dmemAddr",  dmemAddr,           32'h40);
    advance();
    aux_drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFE_F00E);
    sample();
    chk("lk2_auxGnt",    {31'd0, auxGnt},    32'd1);
    chk("lk2_coreStall", {31'd0, coreStall}, 32'd1);
    chk("lk2_dmemWen",   {31'd0, dmemWen},   32'd1);
    chk("lk2_rvalid",    {31'd0, auxRvalid}, 32'd1);
    chk_rdata("lk1_rdata");
    advance();
    core_drive(1'b1, 1'b0, 32'h40, 32'h0);
    aux_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("lk3_coreStall", {31'd0, coreStall}, 32'd0);
    chk("lk3_auxGnt",    {31'd0, auxGnt},    32'd0);
    chk("lk3_state",     {31'd0, dbg_state}, 32'd0);
    chk("lk3_coreRdata", coreRdata,          32'hCAFE_F00E);
    chk("lk3_rvalid",    {31'd0, auxRvalid}, 32'd0);

    // Continuous core and aux contention.
    advance();
    core_drive(1'b1, 1'b0, 32'h100, 32'h0);
    aux_drive(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      sample();
      chk($sformatf("stv_deny%0d_auxGnt", c),    {31'd0, auxGnt},    32'd0);
      chk($sformatf("stv_deny%0d_coreStall", c), {31'd0, coreStall}, 32'd0);
      advance();
    end
    sample();
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("stv_force_auxGnt",    {31'd0, auxGnt},    32'd1);
    chk("stv_force_coreStall", {31'd0, coreStall}, 32'd1);
    exp_q.push_back(32'h1234_5678);
    advance();
    aux_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("stv_after_coreStall", {31'd0, coreStall}, 32'd0);
    chk("stv_after_rvalid",    {31'd0, auxRvalid}, 32'd1);
    chk_rdata("stv_rdata");
`else
    chk("stv_nforce_auxGnt",    {31'd0, auxGnt},    32'd0);
    chk("stv_nforce_coreStall", {31'd0, coreStall}, 32'd0);
    chk("stv_nforce_coreRdata", coreRdata,          32'hDEAD_BEEF);
    advance();
    aux_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("stv_after_rvalid", {31'd0, auxRvalid}, 32'd0);
`endif

    // Reset while locked.
    advance();
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    aux_drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    sample();
    chk("rl_enter_auxGnt", {31'd0, auxGnt}, 32'd1);
    advance();
    rst = 1'b1;
    core_drive(1'b1, 1'b0, 32'h80, 32'h0);
    aux_drive(1'b1, 1'b1, 1'b1, 32'h80, 32'h1111_1111);
    sample();
    chk("rl_auxGnt",    {31'd0, auxGnt},    32'd0);
    chk("rl_dmemWen",   {31'd0, dmemWen},   32'd0);
    chk("rl_coreStall", {31'd0, coreStall}, 32'd0);
    advance();
    rst = 1'b0;
    sample();
    chk("rl_rvalid",    {31'd0, auxRvalid}, 32'd0);
    chk("rl_state",     {31'd0, dbg_state}, 32'd0);
    chk("rl_coreStall2", {31'd0, coreStall}, 32'd0);
    chk("rl_auxGnt2",   {31'd0, auxGnt},    32'd0);
    chk("rl_mem_kept",  coreRdata,          32'd0);

    advance();
    core_drive(1'b0, 1'b0, 32'h0, 32'h0);
    aux_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("end_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the core's memory stage (requester 0) and an auxiliary requester (debug/DMA, requester 1). It sits between the memory stage outputs and the data memory. Memory reads are combinational and writes commit at the clock edge. The block grants one requester per cycle, stalls the core when it loses the port, supports locked auxiliary sequences (read-modify-write), and returns auxiliary read data one cycle after grant.

## Interface
- STARVE_LIMIT, 4: consecutive denied auxiliary cycles before a forced grant (range 1–15).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- coreReq  in  1  memory stage has a load/store this cycle
- coreWen  in  1  core store
- coreAddr  in  32  core byte address
- coreWdata  in  32  core store data
- coreSize  in  3  core load/store size/sign code, passed through unchanged
- coreRdata  out  32  load data to the memory stage (combinational)
- coreStall  out  1  core lost the port; hold the memory stage and freeze upstream
- auxReq  in  1  auxiliary request valid; must be held stable until auxGnt
- auxWen, auxAddr[32], auxWdata[32], auxSize[3]  in  auxiliary request fields
- auxLock  in  1  keep the port for the next auxiliary beat
- auxGnt  out  1  auxiliary beat accepted this cycle
- auxRvalid  out  1  one-cycle pulse: auxRdata is valid
- auxRdata  out  32  registered auxiliary read data
- dmemAddr[32], dmemWdata[32], dmemSize[3], dmemWen[1]  out  memory port
- dmemRdata  in  32  combinational memory read data

## Operation
- States: OWN_CORE (reset state) and AUX_LOCKED.
- OWN_CORE:
  - coreReq=1: core is granted unless a starvation force applies (see Configuration).
  - coreReq=0 and auxReq=1: aux is granted.
  - No request: memory mux selects the core fields and dmemWen=0.
- Any aux grant with auxLock=1 moves to AUX_LOCKED.
- AUX_LOCKED:
  - Aux has absolute priority. auxGnt = auxReq.
  - coreStall = coreReq.
  - A granted beat with auxLock=0 returns to OWN_CORE.
  - Cycles with auxReq=0 keep the lock and leave the memory port idle (dmemWen=0).
- Mux: the granted requester drives addr/wdata/size/wen. dmemWen = wen of the granted requester, otherwise 0.
- coreStall=1 exactly when coreReq=1 and the aux requester holds the grant.
- coreRdata = dmemRdata every cycle. It is only meaningful when the core is granted.
- Aux read (auxGnt=1, auxWen=0): auxRdata is captured from dmemRdata at the edge; auxRvalid=1 for the next cycle only. Aux writes produce no auxRvalid.
- Simultaneous auxGnt and rst: rst wins. Nothing is captured and the memory is not written.
- Reset mid-lock returns to OWN_CORE. A pending aux request is re-arbitrated normally after reset.

## Timing
- Grant, stall and memory mux are combinational, with zero-cycle latency.
- Aux read latency is 1 cycle, from the auxGnt edge to auxRvalid.
- Reset values:
  - state=OWN_CORE, auxRvalid=0, auxRdata=0, starve counter=0.
  - While rst=1: auxGnt=0, coreStall=0, dmemWen=0.
- Core handshake: when coreStall=1, the memory stage must present identical request fields next cycle. The block does not register core requests.
- Aux handshake: valid/ready with auxReq/auxGnt. Fields may change only after a granted cycle.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments each cycle auxReq=1 && auxGnt=0 in OWN_CORE, saturating at STARVE_LIMIT.
  - When counter == STARVE_LIMIT, aux is granted even if coreReq=1, and coreStall=coreReq.
  - The counter clears on any auxGnt, and on reset.
- Undefined:
  - No counter; fixed core priority. Aux is granted only on core-idle cycles or in AUX_LOCKED.
  - Aux may starve indefinitely under continuous core traffic.

## Test plan
- Core store 0xDEADBEEF to 0x100, auxReq idle -> dmemWen=1, dmemAddr=0x100, coreStall=0, auxGnt=0.
- Core idle, aux read 0x200 (memory holds 0x12345678) -> auxGnt=1 that cycle; next cycle auxRvalid=1, auxRdata=0x12345678; following cycle auxRvalid=0.
- Aux read 0x40 with auxLock=1, then aux write 0x40 with auxLock=0, coreReq=1 throughout -> coreStall=1 for both beats, core granted the third cycle, coreStall=0.
- Guard enabled, STARVE_LIMIT=4, coreReq=1 and auxReq=1 continuously -> auxGnt=0 for 4 cycles, auxGnt=1 and coreStall=1 on the 5th, core granted on the 6th. Guard disabled -> auxGnt never asserts.
- rst asserted while in AUX_LOCKED with auxReq=1 -> auxGnt=0, dmemWen=0, auxRvalid=0. After rst deasserts with coreReq=1, the core is granted and coreStall=0.
